resize_wr_sched: RTL and testbench
==================================

RESIZE_WR_SCHED -- requirements
Module: resize_wr_sched

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 32, byte-address width.
- BURST_MAX, 16, maximum beats per burst, 1..256.
- CNT_W, 10, width of the FIFO read-side data count.

REQ-002 The block SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame-start pulse.
- base_addr  in  ADDR_W  frame byte base address, 8-byte aligned.
- line_beats  in  12  64-bit beats per line.
- line_stride  in  ADDR_W  byte distance between line starts.
- num_lines  in  12  lines per frame.
- fifo_rd_count  in  CNT_W  beats available in the 64-bit pixel FIFO.
- fifo_full  in  1  pixel FIFO full flag.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  write master accepts command.
- cmd_addr  out  ADDR_W  burst byte address.
- cmd_len  out  8  burst beats minus 1.
- cmd_done  in  1  one-cycle pulse: write master finished the current burst.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.
- ovf  out  1  sticky overflow flag.

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, WAIT_DATA, ISSUE, WAIT_DONE and UPDATE; all outputs SHALL be registered.
REQ-004 In IDLE, a start=1 SHALL latch base_addr, line_beats, line_stride and num_lines, then go to WAIT_DATA next cycle; busy SHALL be 1 from that cycle until IDLE is re-entered.
REQ-005 A start received while busy=1 SHALL be ignored; a mid-frame change on any configuration input SHALL have no effect.
REQ-006 If line_beats=0 or num_lines=0 at start, the block SHALL issue no command and pulse frame_done one cycle after start.
REQ-007 In WAIT_DATA, the burst length SHALL be len=min(BURST_MAX, remaining beats in the current line); the state SHALL move to ISSUE in the cycle after fifo_rd_count>=len is sampled.
REQ-008 In ISSUE, the command and handshake SHALL follow these rules:
- cmd_valid=1, cmd_addr=current address, cmd_len=len-1.
- All three outputs stable until the cycle where cmd_valid && cmd_ready; then go to WAIT_DONE.
- cmd_valid low in every other state.
REQ-009 In WAIT_DONE, the block SHALL wait for cmd_done then go to UPDATE; cmd_done in any other state SHALL be ignored.
REQ-010 UPDATE SHALL last one cycle and do the following:
- address += len*8, remaining -= len.
- If remaining=0: line += 1, address = line start + line_stride, remaining = line_beats.
- If the completed line was line num_lines-1, pulse frame_done, go to IDLE.
- Otherwise go to WAIT_DATA.
REQ-011 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error.
REQ-012 A burst SHALL never cross a line boundary, and at most one command SHALL be outstanding.

Reset
REQ-013 When rst_n=0, the block SHALL enter IDLE and clear all outputs, counters and latched configuration to 0, including mid-burst; a pending command SHALL be dropped.
REQ-014 The first start SHALL be honoured on the first rising clk edge after rst_n deasserts.

Configuration
REQ-015 With macro WR_SCHED_OVF_EN defined, ovf SHALL set when fifo_full=1 is sampled while busy=1, and SHALL clear only on reset or on an accepted start.
REQ-016 With WR_SCHED_OVF_EN undefined, ovf SHALL be constant 0 and fifo_full SHALL be ignored.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- base=0x1000, line_beats=40, stride=0x200, num_lines=2, count=1023, ready=1, done 2 cycles after accept -> commands (0x1000,15), (0x1080,15), (0x1100,7), (0x1200,15), (0x1280,15), (0x1300,7); frame_done once.
- count held at 15 with len=16 -> no cmd_valid; count raised to 16 -> cmd_valid the next cycle.
- cmd_ready low for 5 cycles -> cmd_valid, cmd_addr and cmd_len stable for all 5 cycles.
- num_lines=0 -> no command, frame_done one cycle after start, busy=1 for that one cycle only.
- rst_n pulsed low during WAIT_DONE -> all outputs 0; a new start then restarts from base_addr.
- WR_SCHED_OVF_EN defined, fifo_full pulsed while busy -> ovf=1 until the next start.

Source files
------------

// File: rtl/resize_wr_sched_if.sv
// Burst command channel between the write scheduler and the write master.
// The scheduler drives the command; the master accepts it and reports completion.
interface resize_wr_sched_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              cmd_done;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_len,
        input  cmd_ready,
        input  cmd_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_len,
        output cmd_ready,
        output cmd_done
    );
endinterface

// File: rtl/resize_wr_sched.sv
// Frame write-burst scheduler: splits each line into bursts of at most BURST_MAX beats.
// Optional overflow flag enabled by defining WR_SCHED_OVF_EN.
module resize_wr_sched #(
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 16,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [11:0]       line_beats,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic [11:0]       num_lines,
    input  logic [CNT_W-1:0]  fifo_rd_count,
    input  logic              fifo_full,
    resize_wr_sched_if.master cmd,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        ISSUE,
        WAIT_DONE,
        UPDATE
    } state_t;

    localparam logic [11:0] LMAX  = 12'(BURST_MAX);
    localparam int          CMP_W = (CNT_W > 12) ? CNT_W : 12;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [11:0]       r_beats;
    logic [11:0]       w_beats_nxt;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] w_stride_nxt;
    logic [11:0]       r_lines;
    logic [11:0]       w_lines_nxt;

    logic [ADDR_W-1:0] r_line_start;
    logic [ADDR_W-1:0] w_line_start_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [11:0]       r_rem;
    logic [11:0]       w_rem_nxt;
    logic [11:0]       r_line;
    logic [11:0]       w_line_nxt;

    logic              r_cmd_valid;
    logic              w_cmd_valid_nxt;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [ADDR_W-1:0] w_cmd_addr_nxt;
    logic [7:0]        r_cmd_len;
    logic [7:0]        w_cmd_len_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_frame_done;
    logic              w_frame_done_nxt;

    logic [11:0]       w_len;
    logic [CMP_W-1:0]  w_cnt_x;
    logic [CMP_W-1:0]  w_len_x;
    logic              w_avail;
    logic              w_empty;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [11:0]       w_rem_dec;
    logic [ADDR_W-1:0] w_next_line;
    logic              w_last_line;

    // Burst never spans past the end of the current line
    assign w_len       = (r_rem > LMAX) ? LMAX : r_rem;
    assign w_cnt_x     = CMP_W'(fifo_rd_count);
    assign w_len_x     = CMP_W'(w_len);
    assign w_avail     = (w_cnt_x >= w_len_x);
    assign w_empty     = (r_beats == 12'd0) || (r_lines == 12'd0);
    assign w_step      = ADDR_W'({w_len, 3'b000});
    assign w_addr_inc  = r_addr + w_step;
    assign w_rem_dec   = r_rem - w_len;
    assign w_next_line = r_line_start + r_stride;
    assign w_last_line = (r_line == (r_lines - 12'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beats      <= '0;
            r_stride     <= '0;
            r_lines      <= '0;
            r_line_start <= '0;
            r_addr       <= '0;
            r_rem        <= '0;
            r_line       <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beats      <= w_beats_nxt;
            r_stride     <= w_stride_nxt;
            r_lines      <= w_lines_nxt;
            r_line_start <= w_line_start_nxt;
            r_addr       <= w_addr_nxt;
            r_rem        <= w_rem_nxt;
            r_line       <= w_line_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_cmd_addr   <= w_cmd_addr_nxt;
            r_cmd_len    <= w_cmd_len_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_beats_nxt      = r_beats;
        w_stride_nxt     = r_stride;
        w_lines_nxt      = r_lines;
        w_line_start_nxt = r_line_start;
        w_addr_nxt       = r_addr;
        w_rem_nxt        = r_rem;
        w_line_nxt       = r_line;
        w_cmd_valid_nxt  = 1'b0;
        w_cmd_addr_nxt   = r_cmd_addr;
        w_cmd_len_nxt    = r_cmd_len;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_beats_nxt      = line_beats;
                    w_stride_nxt     = line_stride;
                    w_lines_nxt      = num_lines;
                    w_line_start_nxt = base_addr;
                    w_addr_nxt       = base_addr;
                    w_rem_nxt        = line_beats;
                    w_line_nxt       = 12'd0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // An empty frame finishes without issuing anything
                if (w_empty) begin
                    w_busy_nxt       = 1'b0;
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = IDLE;
                end else if (w_avail) begin
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_addr_nxt  = r_addr;
                    w_cmd_len_nxt   = 8'(w_len - 12'd1);
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                w_cmd_valid_nxt = 1'b1;
                if (r_cmd_valid && cmd.cmd_ready) begin
                    w_cmd_valid_nxt = 1'b0;
                    w_state_nxt     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd.cmd_done) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                w_addr_nxt  = w_addr_inc;
                w_rem_nxt   = w_rem_dec;
                w_state_nxt = WAIT_DATA;
                if (w_rem_dec == 12'd0) begin
                    if (w_last_line) begin
                        w_busy_nxt       = 1'b0;
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = IDLE;
                    end else begin
                        w_line_nxt       = r_line + 12'd1;
                        w_line_start_nxt = w_next_line;
                        w_addr_nxt       = w_next_line;
                        w_rem_nxt        = r_beats;
                    end
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd.cmd_valid = r_cmd_valid;
    assign cmd.cmd_addr  = r_cmd_addr;
    assign cmd.cmd_len   = r_cmd_len;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;

`ifdef WR_SCHED_OVF_EN
    logic r_ovf;

    // Sticky until the next accepted frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_ovf <= 1'b0;
        end else if (fifo_full && r_busy) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_full;

    assign w_unused_full = fifo_full;
    assign ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_resize_wr_sched.sv
// Scoreboard bench for resize_wr_sched: expected bursts are queued at stimulus
// time and a monitor compares every accepted command and frame_done pulse.
module tb_resize_wr_sched;

`ifdef WR_SCHED_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [11:0] line_beats;
    logic [31:0] line_stride;
    logic [11:0] num_lines;
    logic [9:0]  fifo_rd_count;
    logic        fifo_full;
    logic        busy;
    logic        frame_done;
    logic        ovf;

    resize_wr_sched_if #(.ADDR_W(32)) cmd_if ();

    resize_wr_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .line_beats   (line_beats),
        .line_stride  (line_stride),
        .num_lines    (num_lines),
        .fifo_rd_count(fifo_rd_count),
        .fifo_full    (fifo_full),
        .cmd          (cmd_if),
        .busy         (busy),
        .frame_done   (frame_done),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    int          fd_pend = 0;
    bit          done_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [7:0] l);
        exp_addr_q.push_back(a);
        exp_len_q.push_back(l);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((exp_addr_q.size() != 0 || fd_pend != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_addr_q.size() != 0 || fd_pend != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cmds %0d frame_done pending expected 0",
                     nm, exp_addr_q.size(), fd_pend);
        end
        exp_addr_q.delete();
        exp_len_q.delete();
        fd_pend = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        @(negedge clk);
        while (!cmd_if.cmd_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid_seen"}, 32'(cmd_if.cmd_valid), 32'd1);
    endtask

    // Write master model: completion pulse two cycles after acceptance
    initial begin
        cmd_if.cmd_done = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready && done_en) begin
                @(posedge clk);
                #1 cmd_if.cmd_done = 1'b1;
                @(posedge clk);
                #1 cmd_if.cmd_done = 1'b0;
            end
        end
    end

    // Monitor: every accepted command and frame_done is popped and compared
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got addr 0x%0h len %0d expected none",
                             cmd_if.cmd_addr, cmd_if.cmd_len);
                end else begin
                    chk("cmd_addr", cmd_if.cmd_addr, exp_addr_q.pop_front());
                    chk("cmd_len", 32'(cmd_if.cmd_len), 32'(exp_len_q.pop_front()));
                end
            end
            if (rst_n && frame_done) begin
                checks++;
                if (fd_pend == 0) begin
                    errors++;
                    $display("FAIL frame_done_unexpected: got 1 expected 0");
                end else begin
                    fd_pend--;
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        line_beats    = '0;
        line_stride   = '0;
        num_lines     = '0;
        fifo_rd_count = '0;
        fifo_full     = 1'b0;
        cmd_if.cmd_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
        chk("rst_cmd_addr", cmd_if.cmd_addr, 32'd0);
        chk("rst_cmd_len", 32'(cmd_if.cmd_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Two lines of 40 beats, with a mid-frame start/config change ignored
        base_addr        = 32'h1000;
        line_beats       = 12'd40;
        line_stride      = 32'h200;
        num_lines        = 12'd2;
        fifo_rd_count    = 10'd1023;
        cmd_if.cmd_ready = 1'b1;
        push_cmd(32'h1000, 8'd15);
        push_cmd(32'h1080, 8'd15);
        push_cmd(32'h1100, 8'd7);
        push_cmd(32'h1200, 8'd15);
        push_cmd(32'h1280, 8'd15);
        push_cmd(32'h1300, 8'd7);
        fd_pend = 1;
        pulse_start();
        @(negedge clk);
        chk("a_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 100 && exp_addr_q.size() > 5; i++) @(negedge clk);
        base_addr   = 32'hDEAD_0000;
        line_beats  = 12'd3;
        line_stride = 32'h40;
        num_lines   = 12'd7;
        pulse_start();
        wait_drain("a", 500);
        chk("a_busy_end", 32'(busy), 32'd0);

        // FIFO level one short of a full burst holds off the command
        base_addr     = 32'h5000;
        line_beats    = 12'd16;
        line_stride   = 32'h100;
        num_lines     = 12'd1;
        fifo_rd_count = 10'd15;
        push_cmd(32'h5000, 8'd15);
        fd_pend = 1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b_hold_valid", 32'(cmd_if.cmd_valid), 32'd0);
        end
        @(posedge clk);
        #1 fifo_rd_count = 10'd16;
        @(posedge clk);
        @(negedge clk);
        chk("b_valid_next", 32'(cmd_if.cmd_valid), 32'd1);
        wait_drain("b", 200);

        // Stalled ready: command must hold steady
        fifo_rd_count    = 10'd1023;
        base_addr        = 32'h2000;
        line_beats       = 12'd4;
        num_lines        = 12'd1;
        cmd_if.cmd_ready = 1'b0;
        push_cmd(32'h2000, 8'd3);
        fd_pend = 1;
        pulse_start();
        wait_valid("c", 50);
        for (int i = 0; i < 5; i++) begin
            chk("c_stall_valid", 32'(cmd_if.cmd_valid), 32'd1);
            chk("c_stall_addr", cmd_if.cmd_addr, 32'h2000);
            chk("c_stall_len", 32'(cmd_if.cmd_len), 32'd3);
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_if.cmd_ready = 1'b1;
        wait_drain("c", 200);

        // Empty frame: busy for one cycle, frame_done the cycle after start
        num_lines = 12'd0;
        fd_pend = 1;
        pulse_start();
        @(negedge clk);
        chk("d_busy_1st", 32'(busy), 32'd1);
        chk("d_fd_1st", 32'(frame_done), 32'd0);
        @(negedge clk);
        chk("d_busy_2nd", 32'(busy), 32'd0);
        chk("d_fd_2nd", 32'(frame_done), 32'd1);
        wait_drain("d", 20);

        // Reset while waiting for burst completion, then restart
        done_en    = 1'b0;
        base_addr  = 32'h3000;
        line_beats = 12'd8;
        num_lines  = 12'd1;
        push_cmd(32'h3000, 8'd7);
        pulse_start();
        for (int i = 0; i < 50 && exp_addr_q.size() != 0; i++) @(negedge clk);
        chk("e_accepted", 32'(exp_addr_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("e_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
        chk("e_rst_addr", cmd_if.cmd_addr, 32'd0);
        chk("e_rst_len", 32'(cmd_if.cmd_len), 32'd0);
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_fd", 32'(frame_done), 32'd0);
        done_en = 1'b1;
        push_cmd(32'h3000, 8'd7);
        fd_pend = 1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("e_first_start_busy", 32'(busy), 32'd1);
        wait_drain("e", 200);

        // Overflow flag: set by fifo_full while busy, cleared by next start
        base_addr        = 32'h4000;
        line_beats       = 12'd2;
        num_lines        = 12'd1;
        cmd_if.cmd_ready = 1'b0;
        push_cmd(32'h4000, 8'd1);
        fd_pend = 1;
        pulse_start();
        wait_valid("f", 50);
        @(posedge clk);
        #1 fifo_full = 1'b1;
        @(posedge clk);
        #1 fifo_full = 1'b0;
        @(negedge clk);
        chk("f_ovf_set", 32'(ovf), 32'(OVF_ON));
        @(posedge clk);
        #1 cmd_if.cmd_ready = 1'b1;
        wait_drain("f", 200);
        chk("f_ovf_sticky", 32'(ovf), 32'(OVF_ON));
        @(posedge clk);
        #1 fifo_full = 1'b1;
        @(posedge clk);
        #1 fifo_full = 1'b0;
        @(negedge clk);
        chk("f_ovf_idle", 32'(ovf), 32'(OVF_ON));
        num_lines = 12'd0;
        fd_pend = 1;
        pulse_start();
        @(negedge clk);
        chk("f_ovf_clear", 32'(ovf), 32'd0);
        wait_drain("f2", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
